sreg_chain_ctrl: RTL and testbench
==================================

SREG_CHAIN_CTRL -- requirements
Module: sreg_chain_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 42, bits per pixel shift-register chain (min 2).
REQ-002 SHALL have parameter N_CH, default 2, number of independent serial chains (min 1).
REQ-003 SHALL have parameter SCLK_DIV, default 1, clk cycles per sclk half-period (min 1).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd  in  3  opcode.
REQ-008 SHALL have port ch_mask  in  N_CH  per-channel enable, sampled at accept.
REQ-009 SHALL have port data_in  in  N_CH*DATA_W  write data, channel c = data_in[c*DATA_W +: DATA_W], sampled at accept.
REQ-010 SHALL have port cmd_ready  out  1  high when idle and able to accept.
REQ-011 SHALL have port data_out  out  N_CH*DATA_W  captured read-back, same channel packing.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle pulse, data_out updated.
REQ-013 SHALL have port cmd_err  out  1  one-cycle pulse, reserved opcode accepted.
REQ-014 SHALL have port sreg_in  in  N_CH  serial return from each chain.
REQ-015 SHALL have ports shift, sclk, write_cfg  out  1 each  shared chain controls.
REQ-016 SHALL have port serial_out  out  N_CH  serial data into each chain.

Function
REQ-017 Opcodes SHALL be: 000 WRITE (shift out, then latch), 001 READ (shift zeros, capture), 010 EXCHANGE (shift out and capture, no latch), 011 LATCH (write_cfg pulse only), 1xx reserved.
REQ-018 Accept SHALL occur on a clk edge with cmd_valid && cmd_ready; cmd_ready SHALL be low from the next cycle until the command completes; cmd_valid while busy SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, SHIFT, LATCH, DONE; IDLE->SHIFT for 000/001/010, IDLE->LATCH for 011, IDLE stays IDLE for 1xx with cmd_err pulsed the cycle after accept and cmd_ready kept high.
REQ-020 SHIFT SHALL last exactly 2*SCLK_DIV*DATA_W cycles; shift high throughout; each bit: sclk low SCLK_DIV cycles, then high SCLK_DIV cycles; sclk low outside SHIFT.
REQ-021 serial_out[c] SHALL change only at the start of a low phase, MSB first; WRITE/EXCHANGE drive data bits, READ drives 0; masked channels drive 0 for all commands.
REQ-022 sreg_in[c] SHALL be sampled on the last clk edge of each high phase and shifted into the LSB of channel c capture register; after DATA_W bits the first received bit is in the MSB.
REQ-023 Masked channels SHALL not capture; their data_out slice holds its previous value.
REQ-024 SHIFT->LATCH for WRITE; SHIFT->DONE for READ/EXCHANGE; LATCH SHALL hold write_cfg high 2*SCLK_DIV cycles then go to DONE.
REQ-025 DONE SHALL last one cycle: rsp_valid pulses for READ/EXCHANGE only and data_out updates in that same cycle; IDLE with cmd_ready high follows.
REQ-026 Busy duration (cmd_ready low) SHALL be: WRITE 2*D*DATA_W+2*D+1, READ/EXCHANGE 2*D*DATA_W+1, LATCH 2*D+1 cycles (D=SCLK_DIV).
REQ-027 Bit and divider counters SHALL be sized $clog2 of their range, no wrap inside a command.
REQ-028 All outputs SHALL be registered, glitch-free.

Reset
REQ-029 On rst_n low, immediately and regardless of state: FSM to IDLE, cmd_ready=1, shift/sclk/write_cfg/rsp_valid/cmd_err=0, serial_out=0, data_out=0, counters cleared.
REQ-030 Reset mid-command SHALL abort without a write_cfg pulse; the first command after release SHALL run normally.

Verification (DATA_W=42, N_CH=2, SCLK_DIV=1)
REQ-031 Reset: assert rst_n=0 mid-run -> all outputs 0, cmd_ready=1 without a clock edge.
REQ-032 WRITE, ch0=42'h26B4B5F692B, ch1=~that, mask 2'b11 -> serial_out[0] emits 1,0,0,1,1,0... MSB first over 84 cycles, 42 sclk pulses, write_cfg high 2 cycles, cmd_ready low 87 cycles, no rsp_valid.
REQ-033 READ, sreg_in=2'b01 held -> data_out ch0 all ones, ch1 zero, rsp_valid single pulse, write_cfg never high.
REQ-034 EXCHANGE with 42-bit chain model looping serial_out to sreg_in, preloaded 42'h0 -> data_out ch0 = 0, second EXCHANGE returns 42'h26B4B5F692B.
REQ-035 WRITE with ch_mask=2'b01 -> serial_out[1] stays 0, data_out ch1 unchanged; reserved cmd 3'b101 -> cmd_err one pulse, shift/sclk stay 0, cmd_ready stays 1.
REQ-036 Reset at bit 20 of WRITE -> no write_cfg pulse; following LATCH -> write_cfg high exactly 2 cycles, busy 3 cycles.

Source files
------------

// File: rtl/sreg_chain_ctrl.sv
// Controller for N_CH parallel pixel shift-register chains: serialises write data,
// captures read-back bits and pulses the shared latch strobe.
module sreg_chain_ctrl #(
  parameter int DATA_W   = 42,
  parameter int N_CH     = 2,
  parameter int SCLK_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic                   cmd_ready,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic                   rsp_valid,
  output logic                   cmd_err,
  input  logic [N_CH-1:0]        sreg_in,
  output logic                   shift,
  output logic                   sclk,
  output logic                   write_cfg,
  output logic [N_CH-1:0]        serial_out
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    LATCH = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                        state_r, state_s;
  logic [DIV_W-1:0]              div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0]              bit_cnt_r, bit_cnt_s;
  logic                          phase_r, phase_s;
  logic [1:0]                    op_r;
  logic [N_CH-1:0]               mask_r;
  logic [N_CH-1:0][DATA_W-1:0]   tx_r, rx_r, tx_load_s;
  logic                          cmd_ready_r, shift_r, sclk_r, write_cfg_r, rsp_valid_r, cmd_err_r;
  logic [N_CH-1:0]               serial_out_r;
  logic [N_CH*DATA_W-1:0]        data_out_r;
  logic                          accept_s, start_shift_s, half_end_s, bit_end_s, last_bit_s;

  assign accept_s      = cmd_valid && cmd_ready_r && (state_r == IDLE);
  assign start_shift_s = accept_s && !cmd[2] && (cmd[1:0] != 2'b11);
  assign half_end_s    = (div_cnt_r == DIV_LAST);
  assign bit_end_s     = half_end_s && phase_r;
  assign last_bit_s    = (bit_cnt_r == BIT_LAST);

  assign cmd_ready  = cmd_ready_r;
  assign shift      = shift_r;
  assign sclk       = sclk_r;
  assign write_cfg  = write_cfg_r;
  assign rsp_valid  = rsp_valid_r;
  assign cmd_err    = cmd_err_r;
  assign serial_out = serial_out_r;
  assign data_out   = data_out_r;

  // Next state and counters; LATCH reuses the half-period counter as one extra bit time.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    phase_s   = phase_r;
    bit_cnt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        div_cnt_s = '0;
        phase_s   = 1'b0;
        bit_cnt_s = '0;
        if (start_shift_s) begin
          state_s = SHIFT;
        end else if (accept_s && (cmd == 3'b011)) begin
          state_s = LATCH;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT, LATCH: begin
        if (half_end_s) begin
          div_cnt_s = '0;
          phase_s   = ~phase_r;
          if (phase_r) begin
            if (state_r == LATCH) begin
              state_s = DONE;
            end else if (last_bit_s) begin
              state_s   = (op_r == 2'b00) ? LATCH : DONE;
              bit_cnt_s = '0;
            end else begin
              bit_cnt_s = bit_cnt_r + BIT_W'(1);
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Per-channel word to serialise: reads and masked channels send zeros.
  always_comb begin
    tx_load_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_mask[c] && (cmd != 3'b001)) begin
        tx_load_s[c] = data_in[c*DATA_W +: DATA_W];
      end else begin
        tx_load_s[c] = '0;
      end
    end
  end

  // FSM state, counters and control outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      phase_r     <= 1'b0;
      op_r        <= 2'b00;
      mask_r      <= '0;
      cmd_ready_r <= 1'b1;
      shift_r     <= 1'b0;
      sclk_r      <= 1'b0;
      write_cfg_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_cnt_r   <= div_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      phase_r     <= phase_s;
      cmd_ready_r <= (state_s == IDLE);
      shift_r     <= (state_s == SHIFT);
      sclk_r      <= (state_s == SHIFT) && phase_s;
      write_cfg_r <= (state_s == LATCH);
      rsp_valid_r <= (state_r == SHIFT) && (state_s == DONE);
      cmd_err_r   <= accept_s && cmd[2];
      if (accept_s) begin
        op_r   <= cmd[1:0];
        mask_r <= ch_mask;
      end
    end
  end

  // Serial datapath: next bit presented as the high phase ends, return bit sampled on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r         <= '0;
      rx_r         <= '0;
      serial_out_r <= '0;
      data_out_r   <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (start_shift_s) begin
          tx_r[c]         <= tx_load_s[c];
          rx_r[c]         <= '0;
          serial_out_r[c] <= tx_load_s[c][DATA_W-1];
        end else if ((state_r == SHIFT) && bit_end_s) begin
          tx_r[c]         <= {tx_r[c][DATA_W-2:0], 1'b0};
          serial_out_r[c] <= last_bit_s ? 1'b0 : tx_r[c][DATA_W-2];
          if (mask_r[c]) begin
            rx_r[c] <= {rx_r[c][DATA_W-2:0], sreg_in[c]};
            if (last_bit_s && (op_r != 2'b00)) begin
              data_out_r[c*DATA_W +: DATA_W] <= {rx_r[c][DATA_W-2:0], sreg_in[c]};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sreg_chain_ctrl.sv
// Directed bench for sreg_chain_ctrl: scoreboard queue for read-back/error responses,
// per-command timing counters, and a looped-back chain model for EXCHANGE.
module tb_sreg_chain_ctrl;

  localparam logic [41:0] D0   = 42'h26B4B5F692B;
  localparam logic [41:0] DN   = ~D0;
  localparam logic [41:0] ONES = 42'h3FFFFFFFFFF;
  localparam logic [41:0] ALT  = 42'h15555555555;

  typedef struct packed {
    logic        is_err;
    logic [83:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'b000;
  logic [1:0]  ch_mask = 2'b00;
  logic [83:0] data_in = '0;
  logic        cmd_ready, rsp_valid, cmd_err, shift, sclk, write_cfg;
  logic [83:0] data_out;
  logic [1:0]  sreg_in, serial_out;

  logic [41:0] chain0, chain1;
  logic        chain_clr = 1'b0;
  logic        loop_en = 1'b0;
  logic [1:0]  sreg_drv = 2'b00;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          busy_n, wcfg_n, sclk_n, shift_n, rsp_n, err_n, quiet_bad;
  logic [41:0] so0, so1;

  sreg_chain_ctrl #(.DATA_W(42), .N_CH(2), .SCLK_DIV(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .ch_mask    (ch_mask),
    .data_in    (data_in),
    .cmd_ready  (cmd_ready),
    .data_out   (data_out),
    .rsp_valid  (rsp_valid),
    .cmd_err    (cmd_err),
    .sreg_in    (sreg_in),
    .shift      (shift),
    .sclk       (sclk),
    .write_cfg  (write_cfg),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  // External chains shift once per bit, at the edge that ends the sclk high phase.
  always @(posedge clk) begin
    if (chain_clr) begin
      chain0 <= '0;
      chain1 <= '0;
    end else if (sclk) begin
      chain0 <= {chain0[40:0], serial_out[0]};
      chain1 <= {chain1[40:0], serial_out[1]};
    end
  end

  assign sreg_in = loop_en ? {chain1[41], chain0[41]} : sreg_drv;

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_err, input logic [83:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    return e;
  endfunction

  // Monitor: every response pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (rsp_valid || cmd_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got rsp=%0b err=%0b with empty queue", rsp_valid, cmd_err);
      end else begin
        mon_e = exp_q.pop_front();
        check_int("sb_kind_err", int'(cmd_err), int'(mon_e.is_err));
        check_int("sb_kind_rsp", int'(rsp_valid), int'(!mon_e.is_err));
        if (!mon_e.is_err) check_vec("sb_data_out", data_out, mon_e.data);
      end
    end
  end

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] mask,
                         input logic [41:0] d0, input logic [41:0] d1, input int abort_at);
    logic prev_sclk;
    logic done;
    busy_n = 0; wcfg_n = 0; sclk_n = 0; shift_n = 0; rsp_n = 0; err_n = 0;
    so0 = '0; so1 = '0; prev_sclk = 1'b0; done = 1'b0;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    check_int("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd = op; ch_mask = mask; data_in = {d1, d0};
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd = 3'b000; ch_mask = 2'b00; data_in = '0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (cmd_err) err_n++;
      if (cmd_ready) begin
        done = 1'b1;
      end else begin
        busy_n++;
        if (write_cfg) wcfg_n++;
        if (shift) shift_n++;
        if (rsp_valid) rsp_n++;
        if (sclk && !prev_sclk) begin
          sclk_n++;
          so0 = {so0[40:0], serial_out[0]};
          so1 = {so1[40:0], serial_out[1]};
        end
        prev_sclk = sclk;
        if (abort_at != 0 && sclk_n == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          check_int("arst_ready", int'(cmd_ready), 1);
          check_vec("arst_ctl", {77'h0, shift, sclk, write_cfg, rsp_valid, cmd_err, serial_out}, 84'h0);
          check_vec("arst_data", data_out, 84'h0);
          done = 1'b1;
        end
      end
    end
    check_int("cmd_completes", int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check_int("rst_ready", int'(cmd_ready), 1);
    check_vec("rst_ctl", {77'h0, shift, sclk, write_cfg, rsp_valid, cmd_err, serial_out}, 84'h0);
    check_vec("rst_data", data_out, 84'h0);
    rst_n = 1'b1;

    // WRITE both channels
    run_cmd(3'b000, 2'b11, D0, DN, 0);
    check_int("wr_busy", busy_n, 87);
    check_int("wr_sclk", sclk_n, 42);
    check_int("wr_shift", shift_n, 84);
    check_int("wr_wcfg", wcfg_n, 2);
    check_int("wr_rsp", rsp_n, 0);
    check_vec("wr_so0", {42'h0, so0}, {42'h0, D0});
    check_vec("wr_so1", {42'h0, so1}, {42'h0, DN});

    // READ with constant return pattern
    sreg_drv = 2'b01;
    exp_q.push_back(mk_exp(1'b0, {42'h0, ONES}));
    run_cmd(3'b001, 2'b11, D0, DN, 0);
    check_int("rd_busy", busy_n, 85);
    check_int("rd_wcfg", wcfg_n, 0);
    check_int("rd_rsp", rsp_n, 1);
    check_vec("rd_so", {so1, so0}, 84'h0);

    // EXCHANGE through looped-back chains
    loop_en = 1'b1;
    chain_clr = 1'b1;
    @(posedge clk);
    #1 chain_clr = 1'b0;
    exp_q.push_back(mk_exp(1'b0, 84'h0));
    run_cmd(3'b010, 2'b11, D0, DN, 0);
    check_int("ex1_busy", busy_n, 85);
    check_int("ex1_wcfg", wcfg_n, 0);
    exp_q.push_back(mk_exp(1'b0, {DN, D0}));
    run_cmd(3'b010, 2'b11, 42'h0, 42'h0, 0);
    check_int("ex2_rsp", rsp_n, 1);
    loop_en = 1'b0;

    // WRITE with channel 1 masked
    run_cmd(3'b000, 2'b01, ALT, ONES, 0);
    check_int("wm_busy", busy_n, 87);
    check_vec("wm_so0", {42'h0, so0}, {42'h0, ALT});
    check_vec("wm_so1", {42'h0, so1}, 84'h0);
    check_vec("wm_data_out", data_out, {DN, D0});

    // READ with channel 0 masked keeps its old slice
    sreg_drv = 2'b11;
    exp_q.push_back(mk_exp(1'b0, {ONES, D0}));
    run_cmd(3'b001, 2'b10, 42'h0, 42'h0, 0);
    check_int("rm_rsp", rsp_n, 1);

    // Reserved opcode
    exp_q.push_back(mk_exp(1'b1, 84'h0));
    run_cmd(3'b101, 2'b11, D0, DN, 0);
    check_int("rsv_err", err_n, 1);
    check_int("rsv_busy", busy_n, 0);
    quiet_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (shift || sclk || !cmd_ready || cmd_err) quiet_bad++;
    end
    check_int("rsv_quiet", quiet_bad, 0);

    // Reset in the middle of a WRITE, then a clean LATCH
    run_cmd(3'b000, 2'b11, D0, DN, 20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wcfg_n = 0;
    repeat (100) begin
      @(negedge clk);
      if (write_cfg) wcfg_n++;
    end
    check_int("abort_no_wcfg", wcfg_n, 0);
    run_cmd(3'b011, 2'b11, 42'h0, 42'h0, 0);
    check_int("lat_busy", busy_n, 3);
    check_int("lat_wcfg", wcfg_n, 2);
    check_int("lat_sclk", sclk_n, 0);
    check_int("lat_rsp", rsp_n, 0);

    repeat (3) @(negedge clk);
    check_int("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
